// File: rtl/lc3b_types.sv
// Shared LC-3b types plus branch-predictor defaults and the predictor entry layout.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    localparam int unsigned BP_ENTRIES_DEFAULT   = 16;
    localparam int unsigned BP_CTR_WIDTH_DEFAULT = 2;

    // Tag is kept as a full word (PC shifted right past the index bits); the
    // counter field is sized for the widest supported counter.
    typedef struct packed {
        logic     valid;
        lc3b_word tag;
        lc3b_word target;
        logic     uncond;
        logic [3:0] counter;
    } bp_entry_t;

endpackage

// File: rtl/bp_table.sv
// Predictor entry storage with one combinational read port and one
// update/allocate write port.
module bp_table
    import lc3b_types::*;
#(
    parameter int unsigned ENTRIES   = BP_ENTRIES_DEFAULT,
    parameter int unsigned CTR_WIDTH = BP_CTR_WIDTH_DEFAULT,
    localparam int unsigned IW       = $clog2(ENTRIES)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [IW-1:0] rd_index_i,
    output bp_entry_t     rd_entry_o,
    input  logic          upd_valid_i,
    input  logic [IW-1:0] upd_index_i,
    input  lc3b_word      upd_tag_i,
    input  lc3b_word      upd_target_i,
    input  logic          upd_taken_i,
    input  logic          upd_uncond_i
);

    localparam logic [3:0] CtrMax          = 4'((1 << CTR_WIDTH) - 1);
    localparam logic [3:0] CtrWeakTaken    = 4'(1 << (CTR_WIDTH - 1));
    localparam logic [3:0] CtrWeakNotTaken = CtrWeakTaken - 4'd1;

    localparam bp_entry_t ResetEntry = '{
        valid:   1'b0,
        tag:     16'h0000,
        target:  16'h0000,
        uncond:  1'b0,
        counter: CtrWeakNotTaken
    };

    bp_entry_t table_q [ENTRIES];
    bp_entry_t cur_entry;
    bp_entry_t wr_entry;
    logic      wr_en;

    // Read port: no bypass, a same-cycle update is not visible here.
    always_comb begin
        rd_entry_o = table_q[rd_index_i];
    end

    // Update: train on a tag hit, allocate on a taken miss, ignore an untaken miss.
    always_comb begin
        cur_entry = table_q[upd_index_i];
        wr_entry  = cur_entry;
        wr_en     = 1'b0;
        if (upd_valid_i) begin
            if (cur_entry.valid && (cur_entry.tag == upd_tag_i)) begin
                wr_en           = 1'b1;
                wr_entry.uncond = upd_uncond_i;
                if (upd_taken_i) begin
                    wr_entry.target = upd_target_i;
                    if (cur_entry.counter != CtrMax) begin
                        wr_entry.counter = cur_entry.counter + 4'd1;
                    end
                end else if (cur_entry.counter != 4'd0) begin
                    wr_entry.counter = cur_entry.counter - 4'd1;
                end
            end else if (upd_taken_i) begin
                wr_en    = 1'b1;
                wr_entry = '{
                    valid:   1'b1,
                    tag:     upd_tag_i,
                    target:  upd_target_i,
                    uncond:  upd_uncond_i,
                    counter: CtrWeakTaken
                };
            end
        end
    end

    // Entry storage; reset takes priority over any concurrent update.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                table_q[i] <= ResetEntry;
            end
        end else if (wr_en) begin
            table_q[upd_index_i] <= wr_entry;
        end
    end

endmodule

// File: rtl/bp_dirpred.sv
// Branch direction/target predictor: indexing (bimodal or gshare), resolved
// global history and saturating performance counters around bp_table.
module bp_dirpred
    import lc3b_types::*;
#(
    parameter int unsigned ENTRIES   = BP_ENTRIES_DEFAULT,
    parameter int unsigned CTR_WIDTH = BP_CTR_WIDTH_DEFAULT,
    parameter int unsigned GSHARE    = 0,
    localparam int unsigned IW       = $clog2(ENTRIES)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          lookup_valid_i,
    input  lc3b_word      lookup_pc_i,
    output logic          pred_hit_o,
    output logic          pred_taken_o,
    output lc3b_word      pred_target_o,
    output logic [IW-1:0] pred_index_o,
    input  logic          update_valid_i,
    input  lc3b_word      update_pc_i,
    input  lc3b_word      update_target_i,
    input  logic [IW-1:0] update_index_i,
    input  logic          update_taken_i,
    input  logic          update_uncond_i,
    input  logic          update_mispredict_i,
    output logic [15:0]   lookup_count_o,
    output logic [15:0]   mispredict_count_o
);

    logic [IW-1:0] ghr_q, ghr_d;
    logic [15:0]   lookup_count_q, lookup_count_d;
    logic [15:0]   mispredict_count_q, mispredict_count_d;
    bp_entry_t     rd_entry;
    lc3b_word      lookup_tag;
    lc3b_word      update_tag;
    logic          unused_bits;

    // Index/tag split of the lookup PC; bit 0 is the byte offset.
    always_comb begin
        pred_index_o = lookup_pc_i[IW:1] ^ ((GSHARE != 0) ? ghr_q : '0);
        lookup_tag   = lookup_pc_i >> (IW + 1);
        update_tag   = update_pc_i >> (IW + 1);
    end

    bp_table #(
        .ENTRIES   (ENTRIES),
        .CTR_WIDTH (CTR_WIDTH)
    ) u_table (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .rd_index_i   (pred_index_o),
        .rd_entry_o   (rd_entry),
        .upd_valid_i  (update_valid_i),
        .upd_index_i  (update_index_i),
        .upd_tag_i    (update_tag),
        .upd_target_i (update_target_i),
        .upd_taken_i  (update_taken_i),
        .upd_uncond_i (update_uncond_i)
    );

    // Zero-latency prediction outputs, forced to zero without a valid lookup.
    always_comb begin
        pred_hit_o    = lookup_valid_i && rd_entry.valid && (rd_entry.tag == lookup_tag);
        pred_taken_o  = pred_hit_o && (rd_entry.counter[CTR_WIDTH-1] || rd_entry.uncond);
        pred_target_o = pred_hit_o ? rd_entry.target : 16'h0000;
    end

    // History and statistics next state; counters stick at all-ones.
    always_comb begin
        ghr_d              = ghr_q;
        lookup_count_d     = lookup_count_q;
        mispredict_count_d = mispredict_count_q;
        if (update_valid_i) begin
            ghr_d = {ghr_q[IW-2:0], update_taken_i};
        end
        if (lookup_valid_i && (lookup_count_q != 16'hFFFF)) begin
            lookup_count_d = lookup_count_q + 16'd1;
        end
        if (update_valid_i && update_mispredict_i && (mispredict_count_q != 16'hFFFF)) begin
            mispredict_count_d = mispredict_count_q + 16'd1;
        end
    end

    // History and statistics registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ghr_q              <= '0;
            lookup_count_q     <= 16'h0000;
            mispredict_count_q <= 16'h0000;
        end else begin
            ghr_q              <= ghr_d;
            lookup_count_q     <= lookup_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign lookup_count_o     = lookup_count_q;
    assign mispredict_count_o = mispredict_count_q;

    // Offset/index bits not part of the tag, and counter bits above the MSB.
    assign unused_bits = ^{lookup_pc_i[0], update_pc_i[IW:0], rd_entry.counter};

endmodule

// File: doc/bp_dirpred.md
BP_DIRPRED -- requirements
Module: bp_dirpred

Interface
REQ-001 Parameter ENTRIES, default 16, number of predictor entries (power of two, 4..256).
REQ-002 Parameter CTR_WIDTH, default 2, width of each saturating direction counter (1..4).
REQ-003 Parameter GSHARE, default 0, indexing mode (0 = bimodal on PC, 1 = PC XOR global history).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 lookup_valid  in  1  a fetch-stage lookup is presented this cycle.
REQ-007 lookup_pc  in  lc3b_word  PC of the fetched instruction.
REQ-008 pred_hit  out  1  lookup matched a valid entry.
REQ-009 pred_taken  out  1  predicted-taken decision.
REQ-010 pred_target  out  lc3b_word  predicted target address.
REQ-011 pred_index  out  log2(ENTRIES)  index used by the lookup, carried down the pipe with the instruction.
REQ-012 update_valid  in  1  a branch resolved this cycle.
REQ-013 update_pc, update_target  in  lc3b_word each  resolved branch PC and computed target.
REQ-014 update_index  in  log2(ENTRIES)  pred_index captured at lookup for this branch.
REQ-015 update_taken, update_uncond, update_mispredict  in  1 each  resolved direction, JMP/JSR/TRAP flag, prediction-was-wrong flag.
REQ-016 lookup_count, mispredict_count  out  16 each  saturating performance counters.

Function
REQ-017 Index = lookup_pc[IW:1] (IW = log2(ENTRIES)); when GSHARE=1, XOR with the IW-bit global history register (GHR).
REQ-018 Tag = lookup_pc[15:IW+1]; each entry holds valid, tag, target, uncond, counter.
REQ-019 Lookup is combinational, zero latency: pred_hit = valid and tag equal; pred_taken = pred_hit and (counter MSB or uncond); pred_target = entry target when pred_hit, else 16'h0000.
REQ-020 With lookup_valid low, pred_hit, pred_taken and pred_target are 0; pred_index still reflects lookup_pc.
REQ-021 Update writes entry update_index on the clock edge when update_valid is high; tag compared against update_pc.
REQ-022 Update tag hit: counter +1 if taken, -1 if not, saturating at 2^CTR_WIDTH-1 and 0; target overwritten only when taken; uncond overwritten.
REQ-023 Update tag miss and taken: allocate (valid=1, new tag, target, uncond, counter = 2^(CTR_WIDTH-1), weakly taken), replacing any occupant.
REQ-024 Update tag miss and not taken: no state change in the table.
REQ-025 GHR shifts left one bit, inserting update_taken, on every update_valid (resolved history; no speculative history, no repair).
REQ-026 Same-cycle lookup and update to one index: lookup returns pre-update contents (no bypass).
REQ-027 lookup_count +1 per cycle with lookup_valid; mispredict_count +1 per update_valid with update_mispredict; both hold at 16'hFFFF.

Reset
REQ-028 On reset all valid bits cleared, counters = 2^(CTR_WIDTH-1)-1 (weakly not taken), targets and tags 0, GHR 0, both performance counters 0.
REQ-029 Reset dominates a concurrent update; outputs after reset: pred_hit 0, pred_taken 0, pred_target 0.

Structure
REQ-030 lc3b_types gains BP_ENTRIES_DEFAULT, BP_CTR_WIDTH_DEFAULT and a bp_entry_t struct (valid, tag, target, uncond, counter); lc3b_word reused.
REQ-031 Entry storage and the update/allocate logic live in one sub-module, bp_table; bp_dirpred holds indexing, GHR and statistics.

Verification (ENTRIES=16, CTR_WIDTH=2, GSHARE=0 unless stated)
REQ-032 Reset, lookup 0x3000 -> pred_hit 0, pred_taken 0, pred_target 0x0000, lookup_count 1 next cycle.
REQ-033 Update 0x3000 taken target 0x3010 -> next-cycle lookup 0x3000: hit 1, taken 1, target 0x3010; two not-taken updates -> taken 0, hit 1; third not-taken -> counter stays 0.
REQ-034 Alias: allocate 0x3000, then update 0x3020 (same index, different tag) taken target 0x3100 -> lookup 0x3000 hit 0; lookup 0x3020 target 0x3100.
REQ-035 Same-cycle lookup 0x3000 and taken update 0x3000 on a cleared table -> that cycle hit 0; following cycle hit 1.
REQ-036 Untaken update to an empty index -> no allocation, lookup hit 0; update_uncond=1 taken entry -> taken 1 regardless of counter.
REQ-037 GSHARE=1: three taken updates give GHR 4'b0111; lookup 0x3000 reports pred_index 4'h7; mispredict_count saturates at 0xFFFF after 65536+ mispredicts.
